freq_generator: RTL and testbench

Programmable square-wave generator: the transmit-side counterpart to the sensor frequency counter. It drives a clean 50 % duty-cycle tone on `wave_out`, for example to an IR/LED emitter or as loop-back stimulus for the counter, at a period of 2×`half_period` clock cycles. An optional burst mode emits a fixed number of periods and then stops. It sits between the rover's control logic (which loads the period and burst settings) and the emitter pin.

---
 rtl/freq_gen_pkg.sv | 21 ++
 rtl/fg_half_timer.sv | 37 +++
 rtl/freq_generator.sv | 161 ++++++++++++++++
 tb/tb_freq_generator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared types and default widths for the square-wave generator.
// Holds the FSM state encoding and the default counter/burst widths used by
// freq_generator and fg_half_timer.
package freq_gen_pkg;

    localparam int unsigned FG_CNT_W   = 32;
    localparam int unsigned FG_BURST_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        DONE = 2'd3
    } fg_state_t;

    // States in which a waveform is in progress.
    function automatic logic fgIsActive(input fg_state_t s);
        return (s == RUN) || (s == STOP);
    endfunction

endpackage

// File: rtl/fg_half_timer.sv
// fg_half_timer: half-period counter for freq_generator.
// Counts 0 .. limit-1 while enabled and wraps to 0; tc is high on the last
// count of each half-wave. clr has priority and holds the count at 0.
module fg_half_timer
    import freq_gen_pkg::*;
#(
    parameter int unsigned CNT_W = FG_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Unsigned compare against limit-1; limit 1 makes tc permanently high.
    assign tc = (count == (limit - CNT_W'(1)));

    // Half-period counter with synchronous clear and wrap on terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tc) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_generator.sv
// freq_generator: programmable 50 % duty square-wave generator.
// Period is 2*half_period clk cycles; graceful stop never cuts a high phase.
// Optional burst mode (fixed number of periods, then DONE) is compiled in when
// the macro FREQ_GEN_BURST_EN is defined; otherwise operation is continuous,
// burst_len is ignored and done stays low.
module freq_generator
    import freq_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = FG_CNT_W,
    parameter int unsigned BURST_W = FG_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               wave_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_count
);

    fg_state_t        state;
    logic [CNT_W-1:0] hp_reg;
    logic [CNT_W-1:0] hpEff;
    logic             enQ;
    logic             loadTake;
    logic             startReq;
    logic             timerClr;
    logic             timerEn;
    logic             tc;
    logic             burstEnd;

    // Shadow registers only take new values while no waveform is running;
    // a load in the start cycle is bypassed straight into the start decision.
    assign loadTake = load && ((state == IDLE) || (state == DONE));
    assign hpEff    = loadTake ? half_period : hp_reg;
    assign startReq = (state == IDLE) && enQ && (hpEff != '0);
    assign timerClr = !fgIsActive(state);
    assign timerEn  = fgIsActive(state);

    // Enable is registered once; every enable decision acts one edge after sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enQ <= 1'b0;
        end else begin
            enQ <= enable;
        end
    end

    // Half-period shadow register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hp_reg <= '0;
        end else if (loadTake) begin
            hp_reg <= half_period;
        end
    end

`ifdef FREQ_GEN_BURST_EN
    logic [BURST_W-1:0] bl_reg;

    // Burst-length shadow register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bl_reg <= '0;
        end else if (loadTake) begin
            bl_reg <= burst_len;
        end
    end

    // pulse_count equals the number of the period whose falling edge is due,
    // so the burst ends on the falling toggle when it matches bl_reg.
    assign burstEnd = (bl_reg != '0) && (pulse_count == bl_reg);
`else
    logic unusedBurstLen;

    assign unusedBurstLen = ^burst_len;
    assign burstEnd       = 1'b0;
`endif

    fg_half_timer #(
        .CNT_W (CNT_W)
    ) uHalfTimer (
        .clk   (clk),
        .reset (reset),
        .clr   (timerClr),
        .en    (timerEn),
        .limit (hp_reg),
        .tc    (tc)
    );

    // Control FSM with registered wave_out, busy, done and pulse counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wave_out    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    wave_out <= 1'b0;
                    if (startReq) begin
                        // Start is itself the first rising edge: clear then count it.
                        state       <= RUN;
                        wave_out    <= 1'b1;
                        busy        <= 1'b1;
                        pulse_count <= BURST_W'(1);
                    end
                end
                RUN: begin
                    if (!enQ && !wave_out) begin
                        // Low phase: stop at once, suppressing any pending rise.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tc) begin
                        wave_out <= ~wave_out;
                        if (!wave_out) begin
                            if (pulse_count != '1) begin
                                pulse_count <= pulse_count + BURST_W'(1);
                            end
                        end else if (burstEnd) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (!enQ) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enQ) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Always high here; finish the high phase, then go idle.
                    if (tc) begin
                        wave_out <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    wave_out <= 1'b0;
                    if (!enQ) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wave_out <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_generator.sv
// tb_freq_generator: directed, scoreboard-based bench for freq_generator.
// Expected wave_out samples are queued from a bench-side period model and
// popped one per clock. Burst steps run when FREQ_GEN_BURST_EN is defined.
module tb_freq_generator;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BURST_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               load;
    logic [CNT_W-1:0]   half_period;
    logic [BURST_W-1:0] burst_len;
    logic               wave_out;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulse_count;

    int   checks = 0;
    int   errors = 0;
    logic expQ[$];

    always #5 clk = ~clk;

    freq_generator #(
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .half_period (half_period),
        .burst_len   (burst_len),
        .wave_out    (wave_out),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: enable-driven start at edge index s; wave high for hp edges, low for hp.
    task automatic pushRun(input int s, input int hp, input int j0, input int j1);
        for (int j = j0; j <= j1; j++) begin
            if (j < s) expQ.push_back(1'b0);
            else       expQ.push_back((((j - s) / hp) % 2) == 0);
        end
    endtask

    task automatic pushZeros(input int n);
        for (int i = 0; i < n; i++) expQ.push_back(1'b0);
    endtask

    task automatic drain(input string tag, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            step();
            load = 1'b0;
            if (expQ.size() == 0) begin
                chk({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk(tag, {31'd0, wave_out}, {31'd0, e});
            end
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_wave"}, {31'd0, wave_out}, 32'd0);
    endtask

    task automatic startLoad(input int hp, input int bl);
        load        = 1'b1;
        half_period = CNT_W'(hp);
        burst_len   = BURST_W'(bl);
        enable      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; half_period = '0; burst_len = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_wave",  {31'd0, wave_out}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_count", {16'd0, pulse_count}, 32'd0);

        // hp=5 continuous: rise one edge after enable sampled, period 10
        startLoad(5, 0);
        pushRun(1, 5, 0, 24);
        drain("hp5_wave", 25);
        chk("hp5_busy", {31'd0, busy}, 32'd1);
        chk("hp5_count", {16'd0, pulse_count}, 32'd3);
        enable = 1'b0;
        waitIdle("hp5_stop", 40);

        // graceful stop: enable dropped 2 cycles into the high phase
        startLoad(4, 0);
        pushRun(1, 4, 0, 2);
        drain("stop_wave", 3);
        enable = 1'b0;
        pushRun(1, 4, 3, 4);
        drain("stop_wave", 2);
        chk("stop_busy_hi", {31'd0, busy}, 32'd1);
        pushZeros(3);
        drain("stop_wave", 1);
        chk("stop_busy_lo", {31'd0, busy}, 32'd0);
        drain("stop_wave", 2);
        chk("stop_count", {16'd0, pulse_count}, 32'd1);

        // load while busy is ignored
        startLoad(3, 0);
        pushRun(1, 3, 0, 6);
        drain("ldbusy_wave", 7);
        load = 1'b1; half_period = CNT_W'(7);
        pushRun(1, 3, 7, 20);
        drain("ldbusy_wave", 14);
        chk("ldbusy_count", {16'd0, pulse_count}, 32'd4);
        enable = 1'b0;
        waitIdle("ldbusy_stop", 40);

        // minimum period hp=1: toggles every cycle
        startLoad(1, 0);
        pushRun(1, 1, 0, 9);
        drain("hp1_wave", 10);
        chk("hp1_count", {16'd0, pulse_count}, 32'd5);
        enable = 1'b0;
        waitIdle("hp1_stop", 10);

        // hp=0: never starts, enable left high afterwards
        startLoad(0, 0);
        pushZeros(8);
        drain("hp0_wave", 8);
        chk("hp0_busy", {31'd0, busy}, 32'd0);

        // load hp=2 with enable already high in IDLE: bypass, first period 4
        load = 1'b1; half_period = CNT_W'(2);
        pushRun(0, 2, 0, 8);
        drain("bypass_wave", 9);
        chk("bypass_count", {16'd0, pulse_count}, 32'd3);

        // async reset in mid high phase
        #3;
        reset = 1'b1;
        #1;
        chk("arst_wave",  {31'd0, wave_out}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_count", {16'd0, pulse_count}, 32'd0);
        step();
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);
        chk("arst_idle_wave", {31'd0, wave_out}, 32'd0);

`ifdef FREQ_GEN_BURST_EN
        // burst hp=3 len=4: four pulses, one-cycle done, hold until enable low
        enable = 1'b0;
        step();
        step();
        startLoad(3, 4);
        pushRun(1, 3, 0, 21);
        drain("burst_wave", 22);
        chk("burst_done_pre", {31'd0, done}, 32'd0);
        pushZeros(6);
        drain("burst_wave", 1);
        chk("burst_done", {31'd0, done}, 32'd1);
        chk("burst_count", {16'd0, pulse_count}, 32'd4);
        chk("burst_busy", {31'd0, busy}, 32'd0);
        drain("burst_hold", 5);
        chk("burst_done_post", {31'd0, done}, 32'd0);
        chk("burst_hold_count", {16'd0, pulse_count}, 32'd4);
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        pushRun(1, 3, 0, 3);
        drain("burst_restart", 4);
        chk("burst_restart_count", {16'd0, pulse_count}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
